// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline control for the in-order core: per-stage valid/rd tracking, load-use stall,
// branch flush, decode-stage forwarding selects and stall/flush performance counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned NUM_STAGES = 5,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned SEL_W      = $clog2(NUM_STAGES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_valid,
  input  logic [REG_ADDR_W-1:0] dec_rs1,
  input  logic [REG_ADDR_W-1:0] dec_rs2,
  input  logic                  dec_rs1_used,
  input  logic                  dec_rs2_used,
  input  logic [REG_ADDR_W-1:0] dec_rd,
  input  logic                  dec_reg_write,
  input  logic                  dec_is_load,
  input  logic                  branch_taken,
  input  logic                  ext_stall,
  output logic [NUM_STAGES-1:0] stage_valid,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  bubble_ex,
  output logic                  flush_if_id,
  output logic [SEL_W-1:0]      fwd_sel_rs1,
  output logic [SEL_W-1:0]      fwd_sel_rs2,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  is_load;
  } entry_t;

  // Entries exist only for EX onward; ID keeps its own valid bit.
  entry_t           ent_q [NUM_STAGES-1:2];
  entry_t           ent_d [NUM_STAGES-1:2];
  logic             id_valid_q, id_valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic flush;
  logic load_use;
  logic rs1_hit_ex, rs2_hit_ex;

  // Hazard detection
  always_comb begin
    rs1_hit_ex = dec_rs1_used && (dec_rs1 == ent_q[2].rd);
    rs2_hit_ex = dec_rs2_used && (dec_rs2 == ent_q[2].rd);
    load_use   = id_valid_q && ent_q[2].valid && ent_q[2].is_load && ent_q[2].reg_write &&
                 (ent_q[2].rd != '0) && (rs1_hit_ex || rs2_hit_ex);
    flush      = branch_taken && !ext_stall;
  end

  // Control outputs; ext_stall overrides flush, flush overrides load_use.
  always_comb begin
    flush_if_id = flush;
    stall_if    = ext_stall || (load_use && !flush);
    stall_id    = ext_stall || (load_use && !flush);
    bubble_ex   = !ext_stall && (flush || load_use);
  end

  always_comb begin
    stage_valid    = '0;
    stage_valid[0] = fetch_valid && !flush_if_id;
    stage_valid[1] = id_valid_q;
    for (int k = 2; k < NUM_STAGES; k++) begin
      stage_valid[k] = ent_q[k].valid;
    end
  end

  // Forwarding: scan oldest to youngest so the youngest matching producer wins.
  always_comb begin
    fwd_sel_rs1 = '0;
    fwd_sel_rs2 = '0;
    for (int k = NUM_STAGES - 1; k >= 2; k--) begin
      if (ent_q[k].valid && ent_q[k].reg_write && (ent_q[k].rd != '0) &&
          !((k == 2) && ent_q[k].is_load)) begin
        if (dec_rs1_used && (dec_rs1 != '0) && (dec_rs1 == ent_q[k].rd)) begin
          fwd_sel_rs1 = SEL_W'(k);
        end
        if (dec_rs2_used && (dec_rs2 != '0) && (dec_rs2 == ent_q[k].rd)) begin
          fwd_sel_rs2 = SEL_W'(k);
        end
      end
    end
  end

  // Next-state
  always_comb begin
    id_valid_d  = id_valid_q;
    ent_d       = ent_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (!ext_stall) begin
      for (int k = NUM_STAGES - 1; k >= 3; k--) begin
        ent_d[k] = ent_q[k-1];
      end
      if (flush) begin
        id_valid_d = 1'b0;
        ent_d[2]   = '0;
      end else if (load_use) begin
        ent_d[2]   = '0;
      end else begin
        id_valid_d         = fetch_valid;
        ent_d[2].valid     = id_valid_q;
        ent_d[2].rd        = dec_rd;
        ent_d[2].reg_write = dec_reg_write;
        ent_d[2].is_load   = dec_is_load;
      end
    end

    if (stall_id) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_if_id) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      id_valid_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      for (int k = 2; k < NUM_STAGES; k++) begin
        ent_q[k] <= '0;
      end
    end else begin
      id_valid_q  <= id_valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      for (int k = 2; k < NUM_STAGES; k++) begin
        ent_q[k] <= ent_d[k];
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: 5 stages, 4-bit counters so wrap is reachable.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned NumStages = 5;
  localparam int unsigned RegAddrW  = 5;
  localparam int unsigned CntW      = 4;
  localparam int unsigned SelW      = $clog2(NumStages);

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 fetch_valid;
  logic [RegAddrW-1:0]  dec_rs1, dec_rs2, dec_rd;
  logic                 dec_rs1_used, dec_rs2_used, dec_reg_write, dec_is_load;
  logic                 branch_taken, ext_stall;
  logic [NumStages-1:0] stage_valid;
  logic                 stall_if, stall_id, bubble_ex, flush_if_id;
  logic [SelW-1:0]      fwd_sel_rs1, fwd_sel_rs2;
  logic [CntW-1:0]      stall_cnt, flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  pipeline_hazard_ctrl #(
    .NUM_STAGES (NumStages),
    .REG_ADDR_W (RegAddrW),
    .CNT_W      (CntW),
    .SEL_W      (SelW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_valid   (fetch_valid),
    .dec_rs1       (dec_rs1),
    .dec_rs2       (dec_rs2),
    .dec_rs1_used  (dec_rs1_used),
    .dec_rs2_used  (dec_rs2_used),
    .dec_rd        (dec_rd),
    .dec_reg_write (dec_reg_write),
    .dec_is_load   (dec_is_load),
    .branch_taken  (branch_taken),
    .ext_stall     (ext_stall),
    .stage_valid   (stage_valid),
    .stall_if      (stall_if),
    .stall_id      (stall_id),
    .bubble_ex     (bubble_ex),
    .flush_if_id   (flush_if_id),
    .fwd_sel_rs1   (fwd_sel_rs1),
    .fwd_sel_rs2   (fwd_sel_rs2),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic [4:0] rd, input logic we, input logic ld);
    dec_rs1       = rs1;
    dec_rs1_used  = u1;
    dec_rs2       = rs2;
    dec_rs2_used  = u2;
    dec_rd        = rd;
    dec_reg_write = we;
    dec_is_load   = ld;
  endtask

  initial begin
    rst          = 1'b0;
    fetch_valid  = 1'b1;
    branch_taken = 1'b0;
    ext_stall    = 1'b0;
    set_dec(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    repeat (2) cyc();

    // Reset state
    #1;
    check("rst_stage_valid", 32'(stage_valid), 32'b00001);
    check("rst_stall_cnt", 32'(stall_cnt), 0);
    check("rst_flush_cnt", 32'(flush_cnt), 0);
    check("rst_stall_if", 32'(stall_if), 0);
    check("rst_bubble", 32'(bubble_ex), 0);

    rst = 1'b1;
    cyc();                                               // ID becomes valid
    set_dec(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);   // lw x5
    cyc();

    // Load-use: EX = lw x5, ID reads x5
    set_dec(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    #1;
    check("lu_stall_if", 32'(stall_if), 1);
    check("lu_stall_id", 32'(stall_id), 1);
    check("lu_bubble", 32'(bubble_ex), 1);
    check("lu_flush", 32'(flush_if_id), 0);
    check("lu_fwd_ld_ex", 32'(fwd_sel_rs1), 0);
    check("lu_stage_valid", 32'(stage_valid), 32'b00111);
    cyc();
    check("lu_release_stall", 32'(stall_id), 0);
    check("lu_release_bubble", 32'(bubble_ex), 0);
    check("lu_fwd_stage3", 32'(fwd_sel_rs1), 3);
    check("lu_stall_cnt", 32'(stall_cnt), 1);
    check("lu_stage_valid2", 32'(stage_valid), 32'b01011);
    cyc();

    // EX = add x6, stage 4 = lw x5 (forwardable past EX)
    set_dec(5'd6, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0);
    #1;
    check("fwd_rs1_ex", 32'(fwd_sel_rs1), 2);
    check("fwd_rs2_ld_wb", 32'(fwd_sel_rs2), 4);
    check("fwd_no_stall", 32'(stall_id), 0);
    cyc();
    set_dec(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
    cyc();
    set_dec(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    cyc();

    // x7 in stages 2 and 4, x9 in stage 3
    set_dec(5'd9, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
    fetch_valid = 1'b0;
    #1;
    check("fwd_prio_rs2", 32'(fwd_sel_rs2), 2);
    check("fwd_rs1_stage3", 32'(fwd_sel_rs1), 3);
    cyc();
    fetch_valid = 1'b1;
    set_dec(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);   // ID invalid here
    cyc();

    // Stage 2 holds invalid x7, stage 4 valid x7
    set_dec(5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b1, 1'b1);   // ID: lw x0
    #1;
    check("fwd_skip_invalid", 32'(fwd_sel_rs2), 4);
    check("inv_stage_valid", 32'(stage_valid), 32'b11011);
    cyc();

    // x0: EX = lw x0, ID reads x0 on both sources
    set_dec(5'd0, 1'b1, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0);
    #1;
    check("x0_no_stall", 32'(stall_id), 0);
    check("x0_no_bubble", 32'(bubble_ex), 0);
    check("x0_fwd_rs1", 32'(fwd_sel_rs1), 0);
    check("x0_fwd_rs2", 32'(fwd_sel_rs2), 0);
    cyc();
    set_dec(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);   // lw x4
    cyc();

    // Flush together with load-use
    set_dec(5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    branch_taken = 1'b1;
    #1;
    check("fl_flush", 32'(flush_if_id), 1);
    check("fl_stall_if", 32'(stall_if), 0);
    check("fl_stall_id", 32'(stall_id), 0);
    check("fl_bubble", 32'(bubble_ex), 1);
    check("fl_stage_valid", 32'(stage_valid), 32'b11110);
    cyc();
    branch_taken = 1'b0;
    #1;
    check("fl_after_valid", 32'(stage_valid), 32'b11001);
    check("fl_flush_cnt", 32'(flush_cnt), 1);
    check("fl_stall_cnt", 32'(stall_cnt), 1);

    // ext_stall freeze for 3 cycles with a pending branch
    ext_stall    = 1'b1;
    branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("es_stall_if", 32'(stall_if), 1);
      check("es_no_bubble", 32'(bubble_ex), 0);
      check("es_no_flush", 32'(flush_if_id), 0);
      check("es_stage_valid", 32'(stage_valid), 32'b11001);
      cyc();
    end
    ext_stall = 1'b0;
    #1;
    check("es_stall_cnt", 32'(stall_cnt), 4);
    check("es_flush_cnt_held", 32'(flush_cnt), 1);
    check("es_flush_release", 32'(flush_if_id), 1);
    check("es_release_valid", 32'(stage_valid), 32'b11000);
    cyc();
    branch_taken = 1'b0;
    set_dec(5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0);
    #1;
    check("es_flush_cnt", 32'(flush_cnt), 2);
    check("es_after_valid", 32'(stage_valid), 32'b10001);

    // Fill the pipeline, then reset mid-operation while ext_stall is high
    repeat (4) cyc();
    check("full_stage_valid", 32'(stage_valid), 32'b11111);
    check("full_stall_cnt", 32'(stall_cnt), 4);
    rst       = 1'b0;
    ext_stall = 1'b1;
    #1;
    check("rr_stall_id_comb", 32'(stall_id), 1);
    cyc();
    check("rr_stage_valid", 32'(stage_valid), 32'b00001);
    check("rr_stall_cnt", 32'(stall_cnt), 0);
    check("rr_flush_cnt", 32'(flush_cnt), 0);

    // Counter wrap: 16 stalls -> 0, 17 -> 1
    rst = 1'b1;
    repeat (16) cyc();
    check("wrap16_stall_cnt", 32'(stall_cnt), 0);
    cyc();
    check("wrap17_stall_cnt", 32'(stall_cnt), 1);
    check("wrap_stage_valid", 32'(stage_valid), 32'b00001);
    ext_stall = 1'b0;
    #1;
    check("wrap_stall_drop", 32'(stall_id), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Parametrised pipeline-control block for the in-order RISC-V core. It tracks per-stage valid bits and destination-register metadata for a pipeline of `NUM_STAGES` stages, and detects load-use hazards (stall plus bubble). It also issues branch flushes and computes operand-forwarding selects for the decode stage. It replaces the ad-hoc flush logic in the core's top level and adds global stall support and performance counters.

## Interface
- `NUM_STAGES`, 5: pipeline depth; stage 0 = IF, 1 = ID, 2 = EX (branch/load address resolve), 3..N-1 = later stages, last = WB. Legal range ≥ 4.
- `REG_ADDR_W`, 5: register-id width.
- `CNT_W`, 32: performance counter width.
- `SEL_W`, $clog2(NUM_STAGES): forwarding-select width.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-low reset (0 = reset), sampled on `clk` rising edge.
- `fetch_valid` in 1: IF holds a valid instruction.
- `dec_rs1`, `dec_rs2` in REG_ADDR_W: ID source registers.
- `dec_rs1_used`, `dec_rs2_used` in 1: ID instruction reads that source.
- `dec_rd` in REG_ADDR_W: ID destination register.
- `dec_reg_write` in 1: ID instruction writes `dec_rd`.
- `dec_is_load` in 1: ID instruction is a load.
- `branch_taken` in 1: EX resolved a taken branch/jump this cycle.
- `ext_stall` in 1: global freeze request (e.g. memory busy).
- `stage_valid` out NUM_STAGES: bit k = stage k holds a valid instruction; bit 0 = `fetch_valid & ~flush_if_id`.
- `stall_if`, `stall_id` out 1: hold PC / IF-ID register.
- `bubble_ex` out 1: load a zero control word into EX.
- `flush_if_id` out 1: kill IF and ID contents.
- `fwd_sel_rs1`, `fwd_sel_rs2` out SEL_W: 0 = register file; k (2..N-1) = forward from stage k result.
- `stall_cnt`, `flush_cnt` out CNT_W: performance counters.

## Operation
- Internal shift chain, one entry per stage 2..N-1: {valid, rd, reg_write, is_load}. ID's valid bit is a separate register.
- **load_use** (combinational) = ID valid & EX entry valid & EX.is_load & EX.reg_write & EX.rd ≠ 0 & ((rs1_used & rs1 = EX.rd) | (rs2_used & rs2 = EX.rd)).
- **flush** = `branch_taken` & ~`ext_stall`.
- **Priority: rst > ext_stall > flush > load_use.**
- **ext_stall = 1:**
  - All state holds; no bubble.
  - `stall_if` = `stall_id` = 1; `bubble_ex` = 0; `flush_if_id` = 0.
  - `branch_taken` is ignored; the source holds it until the stall drops.
- **flush:**
  - ID valid ← 0.
  - EX entry ← invalid (wrong-path ID instruction dropped).
  - Older entries shift normally.
  - `stall_if` = `stall_id` = 0; `bubble_ex` = 1; load_use is suppressed.
- **load_use (no flush):**
  - ID valid holds; `stall_if` = `stall_id` = 1.
  - EX entry ← invalid; `bubble_ex` = 1.
  - Older entries shift.
- **Normal:**
  - ID valid ← `fetch_valid`.
  - EX entry ← {ID valid, dec_rd, dec_reg_write, dec_is_load}.
  - Entry k+1 ← entry k; the last entry retires.
- **Forwarding (combinational), per source:**
  - Select the lowest k in 2..N-1 whose entry is valid & reg_write & rd = rs & rd ≠ 0, excluding a load in stage 2.
  - If none matches, or rs = 0, or the source is unused, select 0.
- **Counters** (wrap modulo 2^CNT_W):
  - `stall_cnt` += 1 each cycle `stall_id` = 1.
  - `flush_cnt` += 1 each cycle `flush_if_id` = 1.

## Timing
- Reset values:
  - All entry and ID valid bits 0; all rd/flags 0.
  - Both counters 0.
  - `stage_valid[N-1:1]` = 0 (bit 0 follows `fetch_valid`).
  - `stall_*`, `bubble_ex`, `flush_if_id`, `fwd_sel_*` = 0 while the chain is empty.
- Combinational, same cycle as inputs: all hazard and forwarding outputs.
- Registered, one cycle later: state updates.
- A load-use stall lasts exactly 1 cycle: the load moves to stage 3, after which `fwd_sel` selects 3.
- A flush costs 2 bubbles (IF, ID). The branch instruction itself continues to retire.
- Reset asserted mid-operation clears the chain on that edge; no counter update occurs that cycle.

## Test plan
- **Load-use stall:** EX holds a load to x5; ID reads rs1 = x5 → `stall_if` = `stall_id` = `bubble_ex` = 1 for exactly 1 cycle, then `fwd_sel_rs1` = 3 and `stall_cnt` = 1.
- **Forward priority:** ALU writes to x7 in stages 2 and 4; ID reads rs2 = x7 → `fwd_sel_rs2` = 2. With the stage-2 entry invalid → `fwd_sel_rs2` = 4.
- **x0 handling:** a load to x0 in EX and ID reading x0 → no stall, `fwd_sel` = 0.
- **Flush over load-use:** `branch_taken` = 1 together with a load-use condition → `flush_if_id` = 1, `stall_*` = 0; next cycle `stage_valid[1]` = `stage_valid[2]` = 0 and `flush_cnt` = 1.
- **ext_stall freeze:** hold `ext_stall` for 3 cycles with `branch_taken` = 1 → `stage_valid` unchanged, `flush_cnt` unchanged, `stall_cnt` += 3. Flush occurs in the cycle after release.
- **Reset and wrap:** with CNT_W = 4, 17 stall cycles → `stall_cnt` = 1. Drive `rst` = 0 with a full pipeline → next cycle all valids and counters are 0.
